// File: rtl/dram_lsu_pkg.sv
// Shared definitions for the data-BRAM load/store sequencer: op codes,
// funct3 access sizes, FSM state encoding and size helpers.
package dram_lsu_pkg;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ACC1 = 3'd1,
      S_ACC2 = 3'd2,
      S_WAIT = 3'd3,
      S_DONE = 3'd4
   } dram_lsu_state_e;

   // Byte-enable pattern of an access of the given funct3 size at offset 0
   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Number of bytes touched by the given funct3 size
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/dram_lsu_ctrl_if.sv
// Execute-stage handshake plus data-BRAM port of the load/store sequencer.
// slave: the sequencer; master: the execute stage / BRAM side.
interface dram_lsu_ctrl_if #(parameter int RAM_AW = 10);
   logic              start;
   logic [1:0]        op_mode1;
   logic [2:0]        op_mode2;
   logic [31:0]       op1;
   logic [31:0]       op2;
   logic [31:0]       imm_data;
   logic              done;
   logic [31:0]       res;
   logic              err;
   logic              busy;
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_din;
   logic [31:0]       ram_dout;

   modport slave (
      input  start, op_mode1, op_mode2, op1, op2, imm_data, ram_dout,
      output done, res, err, busy, ram_en, ram_we, ram_addr, ram_din
   );

   modport master (
      output start, op_mode1, op_mode2, op1, op2, imm_data, ram_dout,
      input  done, res, err, busy, ram_en, ram_we, ram_addr, ram_din
   );
endinterface

// File: rtl/dram_lsu_align.sv
// Byte-lane steering for the data BRAM: store data/enables shifted into the
// first (lo) and second (hi) word, and load data extracted from a lo/hi word
// pair then sign- or zero-extended by funct3.
module dram_lsu_align
   import dram_lsu_pkg::*;
(
   input  logic [2:0]  f3,
   input  logic [1:0]  off,
   input  logic [31:0] st_data,
   output logic [3:0]  we_lo,
   output logic [3:0]  we_hi,
   output logic [31:0] din_lo,
   output logic [31:0] din_hi,
   input  logic [31:0] ld_lo,
   input  logic [31:0] ld_hi,
   output logic [31:0] ld_res
);

   logic [3:0]  mask;
   logic [4:0]  sh;
   logic [31:0] raw;

   // Shift store lanes up by the byte offset; what falls off the top goes to
   // the next word. A shift by 32 (offset 0) leaves the hi word empty.
   always_comb begin
      mask   = size_mask(f3[1:0]);
      sh     = {off, 3'b000};
      we_lo  = mask << off;
      we_hi  = mask >> (3'd4 - {1'b0, off});
      din_lo = st_data << sh;
      din_hi = st_data >> (6'd32 - {1'b0, sh});
   end

   // Reassemble the addressed bytes at bit 0, then extend to 32 bits
   always_comb begin
      raw = (ld_lo >> sh) | (ld_hi << (6'd32 - {1'b0, sh}));
      case (f3)
         F3_B:    ld_res = {{24{raw[7]}}, raw[7:0]};
         F3_BU:   ld_res = {24'b0, raw[7:0]};
         F3_H:    ld_res = {{16{raw[15]}}, raw[15:0]};
         F3_HU:   ld_res = {16'b0, raw[15:0]};
         default: ld_res = raw;
      endcase
   end

endmodule

// File: rtl/dram_lsu_ctrl.sv
// Load/store sequencer in front of a word-addressed, byte-enabled data BRAM
// with 1-cycle read latency. Computes op1+imm, issues one or two BRAM
// accesses and returns aligned / extended load data on a start/done pulse.
// Build option DRAM_MISALIGN_SPLIT_EN: when defined, accesses crossing a word
// boundary are split into two BRAM transactions; otherwise misaligned H/W
// accesses complete immediately with err=1.
module dram_lsu_ctrl
   import dram_lsu_pkg::*;
#(
   parameter int RAM_AW = 10
)(
   input  logic            clk,
   input  logic            rst,
   dram_lsu_ctrl_if.slave  bus
);

`ifdef DRAM_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   dram_lsu_state_e   state_q, state_d;
   logic [RAM_AW-1:0] word_q, word_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic              ld_q, ld_d;
   logic              split_q, split_d;
   logic              err_q, err_d;
   logic [31:0]       op2_q, op2_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       res_q, res_d;

   // Request decode (only meaningful while IDLE)
   logic [RAM_AW+1:0] ea_lo;
   logic              dec_split, dec_misal, dec_legal, dec_err;

   // BRAM drive and alignment results
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_din;
   logic [3:0]        we_lo, we_hi;
   logic [31:0]       din_lo, din_hi, ld_lo, ld_hi, ld_res;

   // Decode the incoming request; address bits above the BRAM are dropped
   // before the add since they cannot influence the low bits.
   always_comb begin
      ea_lo     = bus.op1[RAM_AW+1:0] + bus.imm_data[RAM_AW+1:0];
      dec_split = ({1'b0, ea_lo[1:0]} + size_bytes(bus.op_mode2[1:0])) > 3'd4;
      dec_misal = (bus.op_mode2[1:0] == 2'b01 && ea_lo[0]) ||
                  (bus.op_mode2[1:0] == 2'b10 && ea_lo[1:0] != 2'b00);
      case (bus.op_mode1)
         OP_LOAD:  dec_legal = bus.op_mode2 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
         OP_STORE: dec_legal = bus.op_mode2 inside {F3_B, F3_H, F3_W};
         default:  dec_legal = 1'b0;
      endcase
      dec_err = !dec_legal || (dec_misal && !SPLIT_EN);
   end

   // Split loads merge the captured first word with the second read
   assign ld_lo = split_q ? lo_q : bus.ram_dout;
   assign ld_hi = split_q ? bus.ram_dout : 32'b0;

   dram_lsu_align u_align (
      .f3      (f3_q),
      .off     (off_q),
      .st_data (op2_q),
      .we_lo   (we_lo),
      .we_hi   (we_hi),
      .din_lo  (din_lo),
      .din_hi  (din_hi),
      .ld_lo   (ld_lo),
      .ld_hi   (ld_hi),
      .ld_res  (ld_res)
   );

   // Sequencer next state and BRAM drive; the BRAM is idle outside ACC1/ACC2
   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      off_d    = off_q;
      f3_d     = f3_q;
      ld_d     = ld_q;
      split_d  = split_q;
      err_d    = err_q;
      op2_d    = op2_q;
      lo_d     = lo_q;
      res_d    = res_q;
      ram_en   = 1'b0;
      ram_we   = 4'b0000;
      ram_addr = '0;
      ram_din  = 32'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               word_d  = ea_lo[RAM_AW+1:2];
               off_d   = ea_lo[1:0];
               f3_d    = bus.op_mode2;
               ld_d    = (bus.op_mode1 == OP_LOAD);
               split_d = dec_split && SPLIT_EN;
               op2_d   = bus.op2;
               err_d   = dec_err;
               state_d = dec_err ? S_DONE : S_ACC1;
            end
         end
         S_ACC1: begin
            ram_en   = 1'b1;
            ram_addr = word_q;
            if (!ld_q) begin
               ram_we  = we_lo;
               ram_din = din_lo;
            end
            if (split_q)   state_d = S_ACC2;
            else if (ld_q) state_d = S_WAIT;
            else           state_d = S_DONE;
         end
         S_ACC2: begin
            ram_en   = 1'b1;
            ram_addr = word_q + RAM_AW'(1);
            if (ld_q) begin
               lo_d = bus.ram_dout;
            end else begin
               ram_we  = we_hi;
               ram_din = din_hi;
            end
            state_d = ld_q ? S_WAIT : S_DONE;
         end
         S_WAIT: begin
            res_d   = ld_res;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and request registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         off_q   <= 2'b0;
         f3_q    <= 3'b0;
         ld_q    <= 1'b0;
         split_q <= 1'b0;
         err_q   <= 1'b0;
         op2_q   <= 32'b0;
         lo_q    <= 32'b0;
         res_q   <= 32'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         ld_q    <= ld_d;
         split_q <= split_d;
         err_q   <= err_d;
         op2_q   <= op2_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
      end
   end

   assign bus.done     = (state_q == S_DONE);
   assign bus.err      = (state_q == S_DONE) && err_q;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.res      = res_q;
   assign bus.ram_en   = ram_en;
   assign bus.ram_we   = ram_we;
   assign bus.ram_addr = ram_addr;
   assign bus.ram_din  = ram_din;

endmodule

// File: tb/tb_dram_lsu_ctrl.sv
// Bench for dram_lsu_ctrl: BRAM model, byte-array reference model of memory
// and load results, directed cases followed by randomized load/store traffic.
module tb_dram_lsu_ctrl;

   localparam int AW = 10;
   localparam int NW = 1 << AW;
   localparam int NB = 4 * NW;

`ifdef DRAM_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic mem_clr;

   always #5 clk = ~clk;

   dram_lsu_ctrl_if #(.RAM_AW(AW)) bus();

   dram_lsu_ctrl #(.RAM_AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Data BRAM: byte-enabled write, read-first, 1-cycle read latency
   logic [31:0] mem [NW];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int w = 0; w < NW; w++) mem[w] <= 32'b0;
      end else if (bus.ram_en) begin
         for (int b = 0; b < 4; b++)
            if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
         bus.ram_dout <= mem[bus.ram_addr];
      end
   end

   // Reference: flat byte memory, byte address wraps at NB
   logic [7:0]  mdl [NB];
   logic [31:0] exp_res;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Observations of the last operation
   int          tx_n;
   logic [AW-1:0] tx_addr [4];
   logic [3:0]  tx_we   [4];
   logic [31:0] tx_din  [4];
   int          o_lat;
   logic        o_err;
   logic [31:0] o_res;

   task automatic model(input logic [1:0] m1, input logic [2:0] f3, input logic [31:0] ea,
                        input logic [31:0] d, output int lat, output logic e);
      int sz, off, base;
      logic legal, misal, split;
      logic [31:0] v;
      legal = (m1 == 2'd0 && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
              (m1 == 2'd1 && f3 inside {3'd0, 3'd1, 3'd2});
      sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off   = int'(ea[1:0]);
      base  = int'(ea[AW+1:0]);
      misal = (off % sz) != 0;
      split = (off + sz) > 4;
      if (!legal || (misal && !SPLIT_EN)) begin
         lat = 1;
         e   = 1'b1;
         return;
      end
      e = 1'b0;
      if (m1 == 2'd1) begin
         for (int k = 0; k < sz; k++) mdl[(base + k) % NB] = d[8*k +: 8];
         lat = split ? 3 : 2;
      end else begin
         v = 32'b0;
         for (int k = 0; k < sz; k++) v[8*k +: 8] = mdl[(base + k) % NB];
         if (!f3[2] && v[8*sz-1])
            for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
         exp_res = v;
         lat = split ? 4 : 3;
      end
   endtask

   task automatic do_op(input logic [1:0] m1, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] i, input logic [31:0] d);
      @(negedge clk);
      bus.op_mode1 = m1;
      bus.op_mode2 = f3;
      bus.op1      = a;
      bus.imm_data = i;
      bus.op2      = d;
      bus.start    = 1'b1;
      o_lat = 0;
      o_err = 1'b0;
      o_res = 32'b0;
      tx_n  = 0;
      for (int c = 1; c <= 8 && o_lat == 0; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.ram_en && tx_n < 4) begin
            tx_addr[tx_n] = bus.ram_addr;
            tx_we[tx_n]   = bus.ram_we;
            tx_din[tx_n]  = bus.ram_din;
            tx_n++;
         end
         if (bus.done) begin
            o_lat = c;
            o_err = bus.err;
            o_res = bus.res;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] m1, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] i, input logic [31:0] d);
      int el;
      logic ee;
      model(m1, f3, a + i, d, el, ee);
      do_op(m1, f3, a, i, d);
      chk({tag, ".lat"}, o_lat, el);
      chk({tag, ".err"}, {31'b0, o_err}, {31'b0, ee});
      chk({tag, ".res"}, o_res, exp_res);
   endtask

   initial begin
      logic [2:0]  f3_tab [10];
      logic [1:0]  m1;
      logic [31:0] op1, ea_t;
      int          r, baddr, ndone;

      f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
      for (int k = 0; k < NB; k++) mdl[k] = 8'h00;
      exp_res = 32'b0;

      rst          = 1'b1;
      mem_clr      = 1'b1;
      bus.start    = 1'b0;
      bus.op_mode1 = 2'b0;
      bus.op_mode2 = 3'b0;
      bus.op1      = 32'b0;
      bus.op2      = 32'b0;
      bus.imm_data = 32'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.done", {31'b0, bus.done}, 32'd0);
      chk("rst.err", {31'b0, bus.err}, 32'd0);
      chk("rst.res", bus.res, 32'd0);
      chk("rst.busy", {31'b0, bus.busy}, 32'd0);
      chk("rst.ram_en", {31'b0, bus.ram_en}, 32'd0);
      chk("rst.ram_we", {28'b0, bus.ram_we}, 32'd0);
      chk("rst.ram_addr", {22'b0, bus.ram_addr}, 32'd0);
      chk("rst.ram_din", bus.ram_din, 32'd0);
      rst     = 1'b0;
      mem_clr = 1'b0;

      // Word store / load
      run_op("sw", 2'd1, 3'd2, 32'h100, 32'h4, 32'hDEADBEEF);
      chk("sw.ntx", tx_n, 1);
      chk("sw.addr", {22'b0, tx_addr[0]}, 32'h41);
      chk("sw.we", {28'b0, tx_we[0]}, 32'hF);
      chk("sw.din", tx_din[0], 32'hDEADBEEF);
      chk("sw.lat_abs", o_lat, 2);
      run_op("lw", 2'd0, 3'd2, 32'h100, 32'h4, 32'h0);
      chk("lw.val", o_res, 32'hDEADBEEF);
      chk("lw.lat_abs", o_lat, 3);

      // Byte/half sign handling
      run_op("sw_pre", 2'd1, 3'd2, 32'h104, 32'h0, 32'h80FF7F01);
      run_op("lb", 2'd0, 3'd0, 32'h100, 32'h7, 32'h0);
      chk("lb.val", o_res, 32'hFFFFFF80);
      run_op("lbu", 2'd0, 3'd4, 32'h107, 32'h0, 32'h0);
      chk("lbu.val", o_res, 32'h00000080);
      run_op("lh", 2'd0, 3'd1, 32'h0, 32'h104, 32'h0);
      chk("lh.val", o_res, 32'h00007F01);

      // Sub-word store keeps neighbour bytes
      run_op("sb", 2'd1, 3'd0, 32'h100, 32'h6, 32'h000000AA);
      chk("sb.we", {28'b0, tx_we[0]}, 32'h4);
      chk("sb.din", tx_din[0], 32'h00AA0000);
      run_op("lw_sb", 2'd0, 3'd2, 32'h104, 32'h0, 32'h0);
      chk("lw_sb.val", o_res, 32'h80AA7F01);

      if (SPLIT_EN) begin
         run_op("sw_split", 2'd1, 3'd2, 32'h10000FFE, 32'h0, 32'h12345678);
         chk("sw_split.ntx", tx_n, 2);
         chk("sw_split.addr0", {22'b0, tx_addr[0]}, 32'h3FF);
         chk("sw_split.we0", {28'b0, tx_we[0]}, 32'hC);
         chk("sw_split.addr1", {22'b0, tx_addr[1]}, 32'h000);
         chk("sw_split.we1", {28'b0, tx_we[1]}, 32'h3);
         run_op("lw_split", 2'd0, 3'd2, 32'h00000FF0, 32'hE, 32'h0);
         chk("lw_split.val", o_res, 32'h12345678);
         chk("lw_split.lat_abs", o_lat, 4);
      end else begin
         run_op("lh_mis", 2'd0, 3'd1, 32'h101, 32'h0, 32'h0);
         chk("lh_mis.ntx", tx_n, 0);
         chk("lh_mis.err_abs", {31'b0, o_err}, 32'd1);
         chk("lh_mis.lat_abs", o_lat, 1);
         chk("lh_mis.res_abs", o_res, 32'h80AA7F01);
      end

      // Illegal operations
      run_op("ill_m1", 2'd3, 3'd2, 32'h100, 32'h0, 32'h0);
      chk("ill_m1.ntx", tx_n, 0);
      chk("ill_m1.err_abs", {31'b0, o_err}, 32'd1);
      run_op("ill_sbu", 2'd1, 3'd4, 32'h100, 32'h0, 32'h55);
      chk("ill_sbu.ntx", tx_n, 0);

      // start held through a load: one completion only
      begin
         int el;
         logic ee;
         model(2'd0, 3'd2, 32'h104, 32'h0, el, ee);
         @(negedge clk);
         bus.op_mode1 = 2'd0;
         bus.op_mode2 = 3'd2;
         bus.op1      = 32'h104;
         bus.imm_data = 32'h0;
         bus.start    = 1'b1;
         ndone = 0;
         for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 4) bus.start = 1'b0;
            if (bus.done) ndone++;
         end
         chk("hold.ndone", ndone, 1);
         chk("hold.res", bus.res, exp_res);
      end

      // Reset while the first store access is on the bus
      @(negedge clk);
      bus.op_mode1 = 2'd1;
      bus.op_mode2 = 3'd2;
      bus.op1      = 32'h120;
      bus.imm_data = 32'h0;
      bus.op2      = 32'hCAFEF00D;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("acc1.ram_en", {31'b0, bus.ram_en}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rstmid.ram_en", {31'b0, bus.ram_en}, 32'd0);
      chk("rstmid.ram_we", {28'b0, bus.ram_we}, 32'd0);
      chk("rstmid.busy", {31'b0, bus.busy}, 32'd0);
      chk("rstmid.res", bus.res, 32'd0);
      exp_res = 32'b0;
      @(negedge clk);
      rst = 1'b0;

      // Random traffic around a small window and the top/bottom wrap point
      for (int it = 0; it < 300; it++) begin
         r  = $urandom_range(0, 19);
         m1 = (r < 9) ? 2'd0 : (r < 18) ? 2'd1 : (r == 18) ? 2'd2 : 2'd3;
         if ($urandom_range(0, 3) == 3) baddr = (NB - 8 + $urandom_range(0, 15)) % NB;
         else                           baddr = 32'h100 + $urandom_range(0, 63);
         op1  = $urandom;
         ea_t = ($urandom & ~(NB - 1)) | baddr;
         run_op("rnd", m1, f3_tab[$urandom_range(0, 9)], op1, ea_t - op1, $urandom);
      end

      // Final memory image against the byte model
      @(negedge clk);
      for (int w = 0; w < NW; w++)
         chk("mem", mem[w], {mdl[4*w+3], mdl[4*w+2], mdl[4*w+1], mdl[4*w]});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dram_lsu_ctrl.md
Name: dram_lsu_ctrl

Overview:
- Load/store sequencer in front of the data BRAM: 32-bit wide, word-addressed, per-byte write enables, 1-cycle read latency.
- Computes the effective address from op1 + imm_data.
- Decodes the access size and sign from op_mode2 (RV32 funct3).
- Issues one or two BRAM transactions, then returns aligned or sign-extended load data on a start/done handshake to the execute stage.

Parameters:
- RAM_AW, 10, BRAM word-address width (depth = 2^RAM_AW words).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request strobe; accepted only in IDLE
- op_mode1  in  2  00 load, 01 store, 1x illegal
- op_mode2  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- op1  in  32  base register (rs1)
- op2  in  32  store data (rs2)
- imm_data  in  32  address offset
- done  out  1  one-cycle completion pulse
- res  out  32  load result; held until the next load completes
- err  out  1  valid with done; illegal op or unsupported misalignment
- busy  out  1  high whenever state != IDLE
- ram_en  out  1  BRAM enable
- ram_we  out  4  BRAM byte write enables
- ram_addr  out  RAM_AW  BRAM word address
- ram_din  out  32  BRAM write data
- ram_dout  in  32  BRAM read data, valid the cycle after ram_en with ram_we=0

Behaviour:
- Reset (async, immediate): state=IDLE, done=0, err=0, res=0, busy=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0.
- On start in IDLE, latch: ea = op1+imm_data (32-bit, wraps), op2, op_mode1, op_mode2.
- Address fields: word = ea[RAM_AW+1:2], higher bits ignored; off = ea[1:0].
- Byte mask by size: B=0001, H=0011, W=1111.
- Misaligned means: H with off[0]=1, or W with off!=0. Any access with off+size>4 needs a split.
- States: IDLE, ACC1, ACC2, WAIT, DONE.
- BRAM outputs are driven only in ACC1/ACC2; otherwise ram_en=0, ram_we=0.
- Illegal op_mode1, or funct3 not listed for the direction (store accepts only 000/001/010): IDLE -> DONE. No BRAM access, err=1.
- ACC1:
  - ram_en=1, ram_addr=word.
  - Store: ram_we=(mask<<off)[3:0], ram_din=op2<<(8*off).
  - Non-split: load -> WAIT, store -> DONE.
  - Split: -> ACC2.
- ACC2:
  - ram_addr=word+1, mod 2^RAM_AW (top word wraps to 0).
  - Store: ram_we=mask>>(4-off), ram_din=op2>>(8*(4-off)).
  - Load: captures the ACC1 word from ram_dout.
  - -> WAIT for load, DONE for store.
- WAIT (load): build raw = ram_dout>>(8*off); for split, OR in ram_dout<<(8*(4-off)) using the captured low word.
- Load result: B sign-extends raw[7:0], BU zero-extends, H/HU likewise from raw[15:0], W is raw. Registered into res on exit to DONE.
- DONE: done=1 and err valid for exactly one cycle, then -> IDLE.
- Stores never modify res.
- Latency (start in cycle T):
  - aligned store: done in T+2
  - aligned load: done in T+3
  - split store: done in T+3
  - split load: done in T+4
  - illegal: done in T+1
- start while busy, including the DONE cycle, is ignored and not queued.
- Reset during a split store may leave the first word written; this is accepted.

Optional Feature:
- Macro: DRAM_MISALIGN_SPLIT_EN.
- Defined: misaligned H/W accesses split into two transactions as described above, err=0.
- Undefined: misaligned accesses go IDLE -> DONE with err=1, no BRAM access, res unchanged. ACC2 is unreachable and may be removed.

Decomposition:
- Package dram_lsu_pkg holds:
  - op_mode1 codes (LOAD=2'b00, STORE=2'b01)
  - funct3 constants
  - the state encoding
  - a size-to-byte-mask function
- One natural sub-module, dram_lsu_align: combinational load extract/sign-extend and store shift/mask. Instantiated once, shared by ACC and WAIT.

Test Plan:
- Word store/load: SW op1=0x100, imm=0x4, op2=0xDEADBEEF -> ram_addr=0x41, we=1111, done at T+2. LW of the same address -> res=0xDEADBEEF, done at T+3.
- Byte sign: preload word 0x41 = 0x80FF7F01. LB ea=0x107 -> res=0xFFFFFF80. LBU ea=0x107 -> 0x00000080. LH ea=0x104 -> 0x00007F01.
- Sub-word store: SB ea=0x106, op2=0x000000AA -> we=0100, din=0x00AA0000. Neighbour bytes preserved on readback.
- Split (macro on): SW ea=0x0FFE (RAM_AW=10) -> ACC1 addr=0x3FF we=1100, ACC2 addr=0x000 we=0011. LW ea=0x0FFE returns op2, done at T+4.
- Macro off: LH ea=0x101 -> done at T+1 with err=1, ram_en stays 0, res unchanged.
- Illegal/robustness:
  - op_mode1=2'b11 -> err=1, done at T+1.
  - start held high during a load -> exactly one done.
  - rst asserted in ACC1 -> ram_en/ram_we drop immediately, state IDLE, res=0.
